// File: rtl/wx_pkg.sv
// Shared types and default widths for the Wx result path.
package wx_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } wx_state_e;

  localparam int WX_DATA_W        = 48;
  localparam int WX_SUM_W         = 56;
  localparam int WX_BLOCK_LEN_MAX = 255;

endpackage

// File: rtl/wx_block_accumulator.sv
// Sums BLOCK_LEN W(x) results and emits one block sum with last and overflow flags.
// Define WX_ACC_MAX_EN to add axis_m_tmax, the largest result accepted in the block.
module wx_block_accumulator
  import wx_pkg::*;
#(
  parameter int DATA_W    = WX_DATA_W,
  parameter int SUM_W     = WX_SUM_W,
  parameter int BLOCK_LEN = 4
) (
  input  logic              in_clock,
  input  logic              in_reset_n,
  input  logic              axis_s_tvalid,
  input  logic [DATA_W-1:0] axis_s_tdata,
  output logic              axis_s_tready,
  output logic              axis_m_tvalid,
  input  logic              axis_m_tready,
  output logic [SUM_W-1:0]  axis_m_tdata,
  output logic              axis_m_tlast,
  output logic              axis_m_tuser
`ifdef WX_ACC_MAX_EN
  ,
  output logic [DATA_W-1:0] axis_m_tmax
`endif
);

  localparam logic [7:0] LAST_CNT = 8'(BLOCK_LEN - 1);

  wx_state_e        state_q, state_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [7:0]       count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             out_vld_q, out_vld_d;
  logic [SUM_W-1:0] out_data_q, out_data_d;
  logic             out_user_q, out_user_d;

  logic             s_hs;
  logic             m_hs;
  logic [SUM_W:0]   din_ext;
  logic [SUM_W:0]   add_full;

  // Extra top bit of the adder captures the carry that marks a wrap.
  assign din_ext  = (SUM_W + 1)'(axis_s_tdata);
  assign add_full = {1'b0, sum_q} + din_ext;
  assign s_hs     = (state_q == ACCUM) && axis_s_tvalid;
  assign m_hs     = out_vld_q && axis_m_tready;

`ifdef WX_ACC_MAX_EN
  logic [DATA_W-1:0] max_q, max_d;
  logic [DATA_W-1:0] out_max_q, out_max_d;
`endif

  always_comb begin
    state_d    = state_q;
    sum_d      = sum_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    out_vld_d  = out_vld_q;
    out_data_d = out_data_q;
    out_user_d = out_user_q;
`ifdef WX_ACC_MAX_EN
    max_d      = max_q;
    out_max_d  = out_max_q;
`endif
    case (state_q)
      ACCUM: begin
        if (s_hs) begin
          sum_d   = add_full[SUM_W-1:0];
          ovf_d   = ovf_q | add_full[SUM_W];
          count_d = count_q + 8'd1;
`ifdef WX_ACC_MAX_EN
          max_d   = (axis_s_tdata > max_q) ? axis_s_tdata : max_q;
`endif
          if (count_q == LAST_CNT) begin
            out_data_d = sum_d;
            out_user_d = ovf_d;
            out_vld_d  = 1'b1;
`ifdef WX_ACC_MAX_EN
            out_max_d  = max_d;
`endif
            state_d    = HOLD;
          end
        end
      end
      HOLD: begin
        // The output beat stays frozen until the sink takes it.
        if (m_hs) begin
          sum_d     = '0;
          count_d   = '0;
          ovf_d     = 1'b0;
          out_vld_d = 1'b0;
`ifdef WX_ACC_MAX_EN
          max_d     = '0;
`endif
          state_d   = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      state_q    <= ACCUM;
      sum_q      <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_user_q <= 1'b0;
`ifdef WX_ACC_MAX_EN
      max_q      <= '0;
      out_max_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      sum_q      <= sum_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
      out_user_q <= out_user_d;
`ifdef WX_ACC_MAX_EN
      max_q      <= max_d;
      out_max_q  <= out_max_d;
`endif
    end
  end

  assign axis_s_tready = (state_q == ACCUM);
  assign axis_m_tvalid = out_vld_q;
  assign axis_m_tdata  = out_data_q;
  assign axis_m_tlast  = out_vld_q;
  assign axis_m_tuser  = out_user_q;
`ifdef WX_ACC_MAX_EN
  assign axis_m_tmax   = out_max_q;
`endif

endmodule

// File: tb/tb_wx_block_accumulator.sv
// Directed bench for wx_block_accumulator: default, 48-bit-sum and single-result-block builds.
module tb_wx_block_accumulator;

  logic        clk;
  logic        rst_n;
  logic        s_tvalid;
  logic [47:0] s_tdata;
  logic        m_tready;
  int          sel;

  logic [2:0]  sv, mr;
  logic [2:0]  s_tready_v, m_tvalid_v, m_tlast_v, m_tuser_v;
  logic [55:0] tdata0;
  logic [47:0] tdata1;
  logic [55:0] tdata2;
`ifdef WX_ACC_MAX_EN
  logic [47:0] tmax0, tmax1, tmax2, obs_tmax;
`endif

  logic        obs_tvalid, obs_tlast, obs_tuser, obs_sready;
  logic [55:0] obs_tdata;

  int checks;
  int failures;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      sv[k] = s_tvalid && (sel == k);
      mr[k] = m_tready && (sel == k);
    end
  end

  wx_block_accumulator #(.DATA_W(48), .SUM_W(56), .BLOCK_LEN(4)) dut0 (
    .in_clock(clk), .in_reset_n(rst_n),
    .axis_s_tvalid(sv[0]), .axis_s_tdata(s_tdata), .axis_s_tready(s_tready_v[0]),
    .axis_m_tvalid(m_tvalid_v[0]), .axis_m_tready(mr[0]), .axis_m_tdata(tdata0),
    .axis_m_tlast(m_tlast_v[0]), .axis_m_tuser(m_tuser_v[0])
`ifdef WX_ACC_MAX_EN
    , .axis_m_tmax(tmax0)
`endif
  );

  wx_block_accumulator #(.DATA_W(48), .SUM_W(48), .BLOCK_LEN(4)) dut1 (
    .in_clock(clk), .in_reset_n(rst_n),
    .axis_s_tvalid(sv[1]), .axis_s_tdata(s_tdata), .axis_s_tready(s_tready_v[1]),
    .axis_m_tvalid(m_tvalid_v[1]), .axis_m_tready(mr[1]), .axis_m_tdata(tdata1),
    .axis_m_tlast(m_tlast_v[1]), .axis_m_tuser(m_tuser_v[1])
`ifdef WX_ACC_MAX_EN
    , .axis_m_tmax(tmax1)
`endif
  );

  wx_block_accumulator #(.DATA_W(48), .SUM_W(56), .BLOCK_LEN(1)) dut2 (
    .in_clock(clk), .in_reset_n(rst_n),
    .axis_s_tvalid(sv[2]), .axis_s_tdata(s_tdata), .axis_s_tready(s_tready_v[2]),
    .axis_m_tvalid(m_tvalid_v[2]), .axis_m_tready(mr[2]), .axis_m_tdata(tdata2),
    .axis_m_tlast(m_tlast_v[2]), .axis_m_tuser(m_tuser_v[2])
`ifdef WX_ACC_MAX_EN
    , .axis_m_tmax(tmax2)
`endif
  );

  always_comb begin
    obs_tvalid = m_tvalid_v[0];
    obs_tlast  = m_tlast_v[0];
    obs_tuser  = m_tuser_v[0];
    obs_sready = s_tready_v[0];
    obs_tdata  = tdata0;
`ifdef WX_ACC_MAX_EN
    obs_tmax   = tmax0;
`endif
    if (sel == 1) begin
      obs_tvalid = m_tvalid_v[1];
      obs_tlast  = m_tlast_v[1];
      obs_tuser  = m_tuser_v[1];
      obs_sready = s_tready_v[1];
      obs_tdata  = {8'h00, tdata1};
`ifdef WX_ACC_MAX_EN
      obs_tmax   = tmax1;
`endif
    end else if (sel == 2) begin
      obs_tvalid = m_tvalid_v[2];
      obs_tlast  = m_tlast_v[2];
      obs_tuser  = m_tuser_v[2];
      obs_sready = s_tready_v[2];
      obs_tdata  = tdata2;
`ifdef WX_ACC_MAX_EN
      obs_tmax   = tmax2;
`endif
    end
  end

  typedef struct {
    int               sel;
    int               n;
    int               gap;
    logic [3:0][47:0] d;
    logic [55:0]      exp_data;
    logic             exp_user;
    logic [47:0]      exp_max;
    string            name;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int idx, input int s, input int n, input int gap,
                         input logic [47:0] d0, input logic [47:0] d1,
                         input logic [47:0] d2, input logic [47:0] d3,
                         input logic [55:0] ed, input logic eu, input logic [47:0] em,
                         input string name);
    tbl[idx].sel      = s;
    tbl[idx].n        = n;
    tbl[idx].gap      = gap;
    tbl[idx].d[0]     = d0;
    tbl[idx].d[1]     = d1;
    tbl[idx].d[2]     = d2;
    tbl[idx].d[3]     = d3;
    tbl[idx].exp_data = ed;
    tbl[idx].exp_user = eu;
    tbl[idx].exp_max  = em;
    tbl[idx].name     = name;
  endtask

  // Called at a negedge; returns at the negedge after the last accepted result.
  task automatic run_block(input vec_t v);
    sel = v.sel;
    for (int i = 0; i < v.n; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = v.d[i];
      @(negedge clk);
      s_tvalid = 1'b0;
      if (i < v.n - 1) begin
        check({v.name, "_early_vld"}, 64'(obs_tvalid), 64'd0);
        for (int g = 0; g < v.gap; g++) begin
          @(negedge clk);
          check({v.name, "_gap_vld"}, 64'(obs_tvalid), 64'd0);
          check({v.name, "_gap_srdy"}, 64'(obs_sready), 64'd1);
        end
      end
    end
    check({v.name, "_vld"},  64'(obs_tvalid), 64'd1);
    check({v.name, "_data"}, 64'(obs_tdata),  64'(v.exp_data));
    check({v.name, "_last"}, 64'(obs_tlast),  64'd1);
    check({v.name, "_user"}, 64'(obs_tuser),  64'(v.exp_user));
    check({v.name, "_srdy"}, 64'(obs_sready), 64'd0);
`ifdef WX_ACC_MAX_EN
    check({v.name, "_max"},  64'(obs_tmax),   64'(v.exp_max));
`endif
  endtask

  task automatic release_beat(input string name);
    m_tready = 1'b1;
    @(negedge clk);
    m_tready = 1'b0;
    check({name, "_rel_vld"},  64'(obs_tvalid), 64'd0);
    check({name, "_rel_srdy"}, 64'(obs_sready), 64'd1);
  endtask

  vec_t v;

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    m_tready = 1'b0;
    sel      = 0;

    set_vec(0, 0, 4, 0, 48'd5, 48'd19, 48'd49, 48'd1, 56'd74, 1'b0, 48'd49, "b2b");
    set_vec(1, 0, 4, 2, 48'd5, 48'd19, 48'd49, 48'd1, 56'd74, 1'b0, 48'd49, "gaps");
    set_vec(2, 0, 4, 0, 48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF,
            48'hFFFF_FFFF_FFFF, 56'h03_FFFF_FFFF_FFFC, 1'b0, 48'hFFFF_FFFF_FFFF, "wide_nowrap");
    set_vec(3, 1, 4, 1, 48'hFFFF_FFFF_FFFF, 48'd2, 48'd1, 48'd1, 56'd3, 1'b1,
            48'hFFFF_FFFF_FFFF, "wrap");
    set_vec(4, 1, 4, 0, 48'd1, 48'd1, 48'd1, 48'd1, 56'd4, 1'b0, 48'd1, "after_wrap");
    set_vec(5, 1, 4, 0, 48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF,
            48'hFFFF_FFFF_FFFF, 56'h00_FFFF_FFFF_FFFC, 1'b1, 48'hFFFF_FFFF_FFFF, "multi_wrap");
    set_vec(6, 2, 1, 0, 48'd19, 48'd0, 48'd0, 48'd0, 56'd19, 1'b0, 48'd19, "len1_a");
    set_vec(7, 2, 1, 0, 48'd5,  48'd0, 48'd0, 48'd0, 56'd5,  1'b0, 48'd5,  "len1_b");

    repeat (2) @(negedge clk);
    check("rst_vld",  64'(obs_tvalid), 64'd0);
    check("rst_data", 64'(obs_tdata),  64'd0);
    check("rst_user", 64'(obs_tuser),  64'd0);
    check("rst_last", 64'(obs_tlast),  64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_srdy", 64'(obs_sready), 64'd1);

    for (int t = 0; t < 8; t++) begin
      run_block(tbl[t]);
      release_beat(tbl[t].name);
    end

    // Backpressure: outputs frozen and no input accepted while the sink stalls.
    v = tbl[0];
    v.name = "bp";
    run_block(v);
    s_tvalid = 1'b1;
    s_tdata  = 48'd1000;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("bp_hold_vld",  64'(obs_tvalid), 64'd1);
      check("bp_hold_data", 64'(obs_tdata),  64'd74);
      check("bp_hold_srdy", 64'(obs_sready), 64'd0);
    end
    s_tdata = 48'd1;
    release_beat("bp");
    set_vec(0, 0, 4, 0, 48'd1, 48'd1, 48'd1, 48'd1, 56'd4, 1'b0, 48'd1, "bp_next");
    run_block(tbl[0]);
    release_beat("bp_next");

    // Reset while a beat is pending drops it at once.
    v.name = "hold_rst";
    run_block(v);
    #2 rst_n = 1'b0;
    #1;
    check("hold_rst_vld",  64'(obs_tvalid), 64'd0);
    check("hold_rst_data", 64'(obs_tdata),  64'd0);
    check("hold_rst_user", 64'(obs_tuser),  64'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("hold_rst_srdy", 64'(obs_sready), 64'd1);

    // Reset mid-block discards the partial sum.
    s_tvalid = 1'b1;
    s_tdata  = 48'd5;
    @(negedge clk);
    s_tdata  = 48'd19;
    @(negedge clk);
    s_tvalid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_vld", 64'(obs_tvalid), 64'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    run_block(tbl[0]);
    release_beat("mid_rst_next");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
